// File: rtl/instr_encoder.sv
// RV32I instruction assembler: packs opcode/register/funct/immediate fields into a 32-bit word
// through a 2-stage elastic pipeline, flagging immediates the format cannot represent.
module instr_encoder #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [6:0]       opcode_i,
   input  logic [4:0]       rd_i,
   input  logic [4:0]       rs1_i,
   input  logic [4:0]       rs2_i,
   input  logic [2:0]       funct3_i,
   input  logic [6:0]       funct7_i,
   input  logic [31:0]      imm_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [31:0]      instr_o,
   output logic             err_o,
   output logic [1:0]       err_code_o,
   output logic [CNT_W-1:0] ok_cnt_o,
   output logic [CNT_W-1:0] err_cnt_o
);

   typedef enum logic [2:0] {FmtI, FmtS, FmtB, FmtU, FmtJ, FmtR, FmtBad} fmt_e;

   logic        s1_v_q;
   logic [6:0]  s1_op_q;
   logic [4:0]  s1_rd_q, s1_rs1_q, s1_rs2_q;
   logic [2:0]  s1_f3_q;
   logic [6:0]  s1_f7_q;
   logic [31:0] s1_imm_q;

   logic        s2_v_q;
   logic [31:0] s2_instr_q;
   logic [1:0]  s2_code_q;

   logic [CNT_W-1:0] ok_cnt_q, err_cnt_q;

   fmt_e        fmt;
   logic [31:0] enc_instr;
   logic [1:0]  enc_code;
   logic        i_rng_ok, b_rng_ok, j_rng_ok;
   logic        s2_en, fire;

   // Immediate fits when every bit above the format's sign bit replicates it.
   assign i_rng_ok = (&s1_imm_q[31:11]) | ~(|s1_imm_q[31:11]);
   assign b_rng_ok = (&s1_imm_q[31:12]) | ~(|s1_imm_q[31:12]);
   assign j_rng_ok = (&s1_imm_q[31:20]) | ~(|s1_imm_q[31:20]);

   always_comb begin
      fmt = FmtBad;
      case (s1_op_q)
         7'b0000011, 7'b1100111, 7'b0010011: fmt = FmtI;
         7'b0100011:                         fmt = FmtS;
         7'b1100011:                         fmt = FmtB;
         7'b0110111, 7'b0010111:             fmt = FmtU;
         7'b1101111:                         fmt = FmtJ;
         7'b0110011:                         fmt = FmtR;
         default:                            fmt = FmtBad;
      endcase
   end

   always_comb begin
      enc_instr = 32'h0;
      enc_code  = 2'd0;
      case (fmt)
         FmtI: begin
            enc_instr = {s1_imm_q[11:0], s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
            if (!i_rng_ok) enc_code = 2'd1;
         end
         FmtS: begin
            enc_instr = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_f3_q, s1_imm_q[4:0], s1_op_q};
            if (!i_rng_ok) enc_code = 2'd1;
         end
         FmtB: begin
            enc_instr = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_f3_q,
                         s1_imm_q[4:1], s1_imm_q[11], s1_op_q};
            if (s1_imm_q[0])    enc_code = 2'd2;
            else if (!b_rng_ok) enc_code = 2'd1;
         end
         FmtU: begin
            enc_instr = {s1_imm_q[31:12], s1_rd_q, s1_op_q};
            if (|s1_imm_q[11:0]) enc_code = 2'd2;
         end
         FmtJ: begin
            enc_instr = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                         s1_rd_q, s1_op_q};
            if (s1_imm_q[0])    enc_code = 2'd2;
            else if (!j_rng_ok) enc_code = 2'd1;
         end
         FmtR: begin
            enc_instr = {s1_f7_q, s1_rs2_q, s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
         end
         default: begin
            enc_instr = 32'h0;
            enc_code  = 2'd3;
         end
      endcase
   end

   assign s2_en      = !s2_v_q || out_ready_i;
   assign in_ready_o = !s1_v_q || s2_en;
   assign fire       = s2_v_q && out_ready_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v_q   <= 1'b0;
         s1_op_q  <= 7'h0;
         s1_rd_q  <= 5'h0;
         s1_rs1_q <= 5'h0;
         s1_rs2_q <= 5'h0;
         s1_f3_q  <= 3'h0;
         s1_f7_q  <= 7'h0;
         s1_imm_q <= 32'h0;
      end else if (in_ready_o) begin
         s1_v_q <= in_valid_i;
         if (in_valid_i) begin
            s1_op_q  <= opcode_i;
            s1_rd_q  <= rd_i;
            s1_rs1_q <= rs1_i;
            s1_rs2_q <= rs2_i;
            s1_f3_q  <= funct3_i;
            s1_f7_q  <= funct7_i;
            s1_imm_q <= imm_i;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_v_q     <= 1'b0;
         s2_instr_q <= 32'h0;
         s2_code_q  <= 2'd0;
      end else if (s2_en) begin
         s2_v_q <= s1_v_q;
         if (s1_v_q) begin
            s2_instr_q <= enc_instr;
            s2_code_q  <= enc_code;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ok_cnt_q  <= '0;
         err_cnt_q <= '0;
      end else if (fire) begin
         if (s2_code_q == 2'd0) begin
            if (!(&ok_cnt_q)) ok_cnt_q <= ok_cnt_q + CNT_W'(1);
         end else begin
            if (!(&err_cnt_q)) err_cnt_q <= err_cnt_q + CNT_W'(1);
         end
      end
   end

   assign out_valid_o = s2_v_q;
   assign instr_o     = s2_instr_q;
   assign err_code_o  = s2_code_q;
   assign err_o       = (s2_code_q != 2'd0);
   assign ok_cnt_o    = ok_cnt_q;
   assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed and round-trip bench for instr_encoder; counters narrowed so saturation is reachable.
module tb_instr_encoder;

   localparam int unsigned CW = 5;
   localparam logic [CW-1:0] CMAX = '1;

   logic          clk, rst_n;
   logic          in_valid, in_ready, out_valid, out_ready, err;
   logic [6:0]    opcode, funct7;
   logic [4:0]    rd, rs1, rs2;
   logic [2:0]    funct3;
   logic [31:0]   imm, instr;
   logic [1:0]    err_code;
   logic [CW-1:0] ok_cnt, err_cnt;

   int checks = 0;
   int failures = 0;
   logic [CW-1:0] ok_exp = '0;
   logic [CW-1:0] err_exp = '0;

   instr_encoder #(.CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid_i(in_valid), .in_ready_o(in_ready),
      .opcode_i(opcode), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2),
      .funct3_i(funct3), .funct7_i(funct7), .imm_i(imm),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .instr_o(instr), .err_o(err), .err_code_o(err_code),
      .ok_cnt_o(ok_cnt), .err_cnt_o(err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                          input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [31:0] im);
      opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
   endtask

   // Caller sits at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic push(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] im);
      int n = 0;
      set_req(op, d, s1, s2, f3, f7, im);
      in_valid = 1'b1;
      while (!in_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("accept", {31'b0, in_ready}, 32'd1);
      if (in_ready) begin
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic pop(output logic [31:0] ins, output logic e, output logic [1:0] code);
      int n = 0;
      out_ready = 1'b1;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("out_valid", {31'b0, out_valid}, 32'd1);
      ins  = instr;
      e    = err;
      code = err_code;
      @(posedge clk); #1;
   endtask

   function automatic logic [CW-1:0] inc(input logic [CW-1:0] c);
      return (c == CMAX) ? c : c + CW'(1);
   endfunction

   task automatic xact(input string tag, input logic [6:0] op, input logic [4:0] d,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] im,
                       input logic [31:0] exp_instr, input logic [1:0] exp_code);
      logic [31:0] ins;
      logic        e;
      logic [1:0]  code;
      push(op, d, s1, s2, f3, f7, im);
      pop(ins, e, code);
      chk({tag, "_instr"}, ins, exp_instr);
      chk({tag, "_code"}, {30'b0, code}, {30'b0, exp_code});
      chk({tag, "_err"}, {31'b0, e}, {31'b0, exp_code != 2'd0});
      if (exp_code == 2'd0) ok_exp = inc(ok_exp);
      else                  err_exp = inc(err_exp);
   endtask

   // Reference immediate generator used to invert the encoding.
   function automatic logic [31:0] imm_of(input logic [31:0] i);
      case (i[6:0])
         7'b0010011: return {{20{i[31]}}, i[31:20]};
         7'b0100011: return {{20{i[31]}}, i[31:25], i[11:7]};
         7'b1100011: return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
         7'b0110111: return {i[31:12], 12'b0};
         7'b1101111: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
         default:    return 32'hDEADBEEF;
      endcase
   endfunction

   initial begin
      logic [31:0] r, im, ins;
      logic [6:0]  op;
      logic        e;
      logic [1:0]  code;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      set_req(7'h0, 5'h0, 5'h0, 5'h0, 3'h0, 7'h0, 32'h0);
      #2;
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
      chk("rst_instr", instr, 32'h0);
      chk("rst_code", {30'b0, err_code}, 32'd0);
      chk("rst_ok_cnt", {27'b0, ok_cnt}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // ADDI latency: accept at edge N, valid visible after edge N+1.
      set_req(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF);
      in_valid = 1'b1;
      chk("addi_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("addi_lat_n", {31'b0, out_valid}, 32'd0);
      @(posedge clk); #1;
      chk("addi_lat_n1", {31'b0, out_valid}, 32'd1);
      chk("addi_instr", instr, 32'hFFF00093);
      chk("addi_err", {31'b0, err}, 32'd0);
      @(posedge clk); #1;
      ok_exp = inc(ok_exp);

      xact("sw",      7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8,       32'h0020A423, 2'd0);
      xact("lui",     7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7, 2'd0);
      xact("jal0",    7'b1101111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0,        32'h0000006F, 2'd0);
      xact("add",     7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'h0,       32'h002081B3, 2'd0);
      xact("sub",     7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'h0,       32'h402081B3, 2'd0);
      xact("addi7ff", 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h7FF,      32'h7FF00093, 2'd0);
      xact("beqm4",   7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC, 32'hFE000EE3, 2'd0);
      xact("beq3",    7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3,        32'h00000163, 2'd2);
      xact("jalrng",  7'b1101111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00100000, 32'h8000006F, 2'd1);
      xact("badop",   7'h7F,      5'd1, 5'd2, 5'd3, 3'd1, 7'd1, 32'h1234,     32'h0,        2'd3);
      chk("err_cnt3", {27'b0, err_cnt}, 32'd3);
      xact("addi800", 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800,      32'h80000093, 2'd1);
      xact("luilow",  7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001, 32'h123452B7, 2'd2);
      xact("bprio",   7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00002001, 32'h00000063, 2'd2);
      chk("ok_cnt8", {27'b0, ok_cnt}, {27'b0, ok_exp});
      chk("err_cnt6", {27'b0, err_cnt}, {27'b0, err_exp});

      // Round trip: random legal immediates must decode back to the original value.
      for (int k = 0; k < 20; k++) begin
         r = $urandom;
         case (k % 5)
            0: begin op = 7'b0010011; im = {{20{r[11]}}, r[11:0]}; end
            1: begin op = 7'b0100011; im = {{20{r[11]}}, r[11:0]}; end
            2: begin op = 7'b1100011; im = {{19{r[12]}}, r[12:1], 1'b0}; end
            3: begin op = 7'b0110111; im = {r[31:12], 12'b0}; end
            default: begin op = 7'b1101111; im = {{11{r[20]}}, r[20:1], 1'b0}; end
         endcase
         push(op, 5'(k), 5'(k + 3), 5'(k + 7), 3'(k), 7'd0, im);
         pop(ins, e, code);
         chk("rt_imm", imm_of(ins), im);
         chk("rt_err", {31'b0, e}, 32'd0);
         ok_exp = inc(ok_exp);
      end
      chk("rt_ok_cnt", {27'b0, ok_cnt}, {27'b0, ok_exp});

      // Backpressure: two fill the pipe, the third waits; output held stable.
      out_ready = 1'b0;
      push(7'b0110011, 5'd1, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0);
      push(7'b0110011, 5'd2, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0);
      set_req(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0);
      in_valid = 1'b1;
      chk("bp_in_ready0", {31'b0, in_ready}, 32'd0);
      chk("bp_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_instr_a", instr, 32'h002080B3);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("bp_hold_instr", instr, 32'h002080B3);
      chk("bp_hold_ready", {31'b0, in_ready}, 32'd0);
      out_ready = 1'b1;
      #1;
      chk("bp_ready_comb", {31'b0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_instr_b", instr, 32'h00208133);
      chk("bp_valid_b", {31'b0, out_valid}, 32'd1);
      @(posedge clk); #1;
      chk("bp_instr_c", instr, 32'h002081B3);
      chk("bp_valid_c", {31'b0, out_valid}, 32'd1);
      @(posedge clk); #1;
      chk("bp_drained", {31'b0, out_valid}, 32'd0);
      for (int k = 0; k < 3; k++) ok_exp = inc(ok_exp);
      chk("ok_cnt_full", {27'b0, ok_cnt}, {27'b0, ok_exp});

      xact("sat", 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h5, 32'h00500093, 2'd0);
      chk("ok_cnt_sat", {27'b0, ok_cnt}, {27'b0, CMAX});

      // Asynchronous reset with two requests in flight.
      out_ready = 1'b0;
      push(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1);
      push(7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_out_valid", {31'b0, out_valid}, 32'd0);
      chk("ar_ok_cnt", {27'b0, ok_cnt}, 32'd0);
      chk("ar_err_cnt", {27'b0, err_cnt}, 32'd0);
      chk("ar_instr", instr, 32'h0);
      chk("ar_in_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      ok_exp = '0;
      err_exp = '0;
      xact("post_rst", 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 32'hFFF00093, 2'd0);
      chk("post_rst_ok", {27'b0, ok_cnt}, {27'b0, ok_exp});
      chk("post_rst_idle", {31'b0, out_valid}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
